// File: rtl/mem_gpio_irq_pkg.sv
// Shared definitions for the memory-mapped GPIO peripheral: register word
// indices, bus FSM states and the byte-lane mask helper.
package gpio_pkg;

  // Only address bits [5:2] take part in decode, so the register index is 4 bits wide.
  localparam int REG_IDX_W = 4;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Register word indices (byte offset / 4).
  localparam reg_idx_t GPIO_DOUT    = 4'd0;  // 0x00 RW
  localparam reg_idx_t GPIO_OE      = 4'd1;  // 0x04 RW
  localparam reg_idx_t GPIO_DIN     = 4'd2;  // 0x08 RO, synchronised pads
  localparam reg_idx_t GPIO_SET     = 4'd3;  // 0x0C WO
  localparam reg_idx_t GPIO_CLR     = 4'd4;  // 0x10 WO
  localparam reg_idx_t GPIO_TGL     = 4'd5;  // 0x14 WO
  localparam reg_idx_t GPIO_RISE_EN = 4'd6;  // 0x18 RW
  localparam reg_idx_t GPIO_FALL_EN = 4'd7;  // 0x1C RW
  localparam reg_idx_t GPIO_PEND    = 4'd8;  // 0x20 RW1C

  // Bus handshake: accept in IDLE, answer in RESP, always return to IDLE.
  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

  // Expand the 4 byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] wstrb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{wstrb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_gpio_irq_sync.sv
// Multi-stage synchroniser for the asynchronous pad inputs. One instance
// covers every pin; each bit is an independent flop chain.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Chain packed oldest-stage-last: slice 0 is the first flop after the pad.
  logic [STAGES*WIDTH-1:0] chain_q;
  logic [STAGES*WIDTH-1:0] chain_d;

  // Shift every pin one stage further down the chain each cycle.
  always_comb begin
    chain_d = {chain_q[(STAGES-1)*WIDTH-1:0], d};
  end

  // Chain flops, cleared by reset so DIN and edge history start at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/mem_gpio_irq.sv
// Memory-mapped GPIO with atomic set/clear/toggle, synchronised inputs,
// per-pin rise/fall pending bits and a registered level interrupt.
module mem_gpio_irq
  import gpio_pkg::*;
#(
  parameter int NGPIO       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  output logic [NGPIO-1:0] gpio_oe,
  output logic [NGPIO-1:0] gpio_do,
  input  logic [NGPIO-1:0] gpio_di,
  output logic             irq
);

  bus_state_e state_q, state_d;
  logic       access;
  logic       wr_en;
  reg_idx_t   idx;
  logic [31:0] wmask;
  logic [NGPIO-1:0] wbits;

  logic [NGPIO-1:0] dout_q, dout_d;
  logic [NGPIO-1:0] oe_q, oe_d;
  logic [NGPIO-1:0] rise_en_q, rise_en_d;
  logic [NGPIO-1:0] fall_en_q, fall_en_d;
  logic [NGPIO-1:0] pend_q, pend_d;
  logic [NGPIO-1:0] din;
  logic [NGPIO-1:0] din_q, din_d;
  logic [NGPIO-1:0] edge_hit;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      rd_val;

  // Address bits outside [5:2] and data bits above NGPIO are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{mem_addr[31:6], mem_addr[1:0], mem_wdata, wmask};

  gpio_sync #(
    .WIDTH (NGPIO),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (gpio_di),
    .q  (din)
  );

  // Bus FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus FSM next state: one response cycle per accepted request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (mem_valid) state_d = BUS_RESP;
      BUS_RESP: state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  // Bus FSM outputs: accept only while idle, so ready never repeats back to back.
  always_comb begin
    access    = (state_q == BUS_IDLE) && mem_valid;
    mem_ready = (state_q == BUS_RESP);
  end

  // Address decode and byte-lane masking of the write data.
  always_comb begin
    idx   = reg_idx_t'(mem_addr[5:2]);
    wmask = lane_mask(mem_wstrb);
    wbits = mem_wdata[NGPIO-1:0] & wmask[NGPIO-1:0];
    wr_en = access && (mem_wstrb != 4'b0000);
  end

  // Read mux: current (pre-write) register contents, zero above NGPIO.
  always_comb begin
    rd_val = '0;
    case (idx)
      GPIO_DOUT:    rd_val[NGPIO-1:0] = dout_q;
      GPIO_OE:      rd_val[NGPIO-1:0] = oe_q;
      GPIO_DIN:     rd_val[NGPIO-1:0] = din;
      GPIO_RISE_EN: rd_val[NGPIO-1:0] = rise_en_q;
      GPIO_FALL_EN: rd_val[NGPIO-1:0] = fall_en_q;
      GPIO_PEND:    rd_val[NGPIO-1:0] = pend_q;
      default:      rd_val = '0;
    endcase
  end

  // Edge detect on the synchronised inputs, gated by the current enables.
  always_comb begin
    din_d    = din;
    edge_hit = (din & ~din_q & rise_en_q) | (~din & din_q & fall_en_q);
  end

  // Register file updates; a new edge overrides a same-cycle PEND clear.
  always_comb begin
    dout_d    = dout_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_d    = pend_q;
    if (wr_en) begin
      case (idx)
        GPIO_DOUT:    dout_d    = (dout_q & ~wmask[NGPIO-1:0]) | wbits;
        GPIO_OE:      oe_d      = (oe_q & ~wmask[NGPIO-1:0]) | wbits;
        GPIO_SET:     dout_d    = dout_q | wbits;
        GPIO_CLR:     dout_d    = dout_q & ~wbits;
        GPIO_TGL:     dout_d    = dout_q ^ wbits;
        GPIO_RISE_EN: rise_en_d = (rise_en_q & ~wmask[NGPIO-1:0]) | wbits;
        GPIO_FALL_EN: fall_en_d = (fall_en_q & ~wmask[NGPIO-1:0]) | wbits;
        GPIO_PEND:    pend_d    = pend_q & ~wbits;
        default:      ;
      endcase
    end
    pend_d  = pend_d | edge_hit;
    irq_d   = |pend_q;
    rdata_d = access ? rd_val : 32'h0;
  end

  // All peripheral state flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q    <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      din_q     <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      din_q     <= din_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gpio_do   = dout_q;
  assign gpio_oe   = oe_q;
  assign irq       = irq_q;
  assign mem_rdata = rdata_q;

endmodule
